// File: rtl/simd_feeder_pkg.sv
// Shared constants and types for the SIMD operand feeder.
// The operand width comes from MAC_BW, normally supplied by param_def.sv.
// A local fallback keeps this slice self-contained.
`ifndef MAC_BW
`define MAC_BW 8
`endif

package simd_feeder_pkg;

    localparam int LANES      = 64;
    localparam int BEAT_LANES = 8;
    localparam int BEATS      = LANES / BEAT_LANES;
    localparam int BW         = `MAC_BW;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    typedef logic [BW-1:0]                operand_t;
    typedef operand_t [LANES-1:0]         lane_vec_t;
    typedef operand_t [BEAT_LANES-1:0]    beat_vec_t;
    // Beat-major storage.
    // Packed, it is bit-identical to lane_vec_t, where lane = beat*BEAT_LANES + j.
    typedef beat_vec_t [BEATS-1:0]        beat_store_t;
    typedef logic [BEAT_W-1:0]            beat_idx_t;

    // True for the beat index that completes a vector.
    function automatic logic is_last_beat(input beat_idx_t idx);
        return idx == beat_idx_t'(BEATS - 1);
    endfunction

endpackage

// File: rtl/simd_operand_feeder_bank.sv
// One ping-pong bank: holds one A/B vector pair plus its EMPTY/FILLING/FULL state.
// The state is exported so the top level and any checker can observe it.
module feeder_bank
    import simd_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  beat_idx_t   wr_idx,
    input  beat_vec_t   wr_a,
    input  beat_vec_t   wr_b,
    input  logic        flush,
    input  logic        clr,
    output bank_state_e state,
    output lane_vec_t   vec_a,
    output lane_vec_t   vec_b
);

    bank_state_e state_q;
    beat_store_t store_a;
    beat_store_t store_b;

    // Bank state machine.
    // Issue empties a FULL bank, and flush abandons a partial fill.
    // A write advances EMPTY/FILLING toward FULL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else if (clr && state_q == FULL) begin
            state_q <= EMPTY;
        end else if (flush) begin
            if (state_q == FILLING) begin
                state_q <= EMPTY;
            end
        end else if (wr_en && state_q != FULL) begin
            state_q <= is_last_beat(wr_idx) ? FULL : FILLING;
        end
    end

    // Operand storage.
    // The storage has no reset because the state alone decides validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store_a[wr_idx] <= wr_a;
            store_b[wr_idx] <= wr_b;
        end
    end

    assign state = state_q;
    assign vec_a = store_a;
    assign vec_b = store_b;

endmodule

// File: rtl/simd_operand_feeder.sv
// simd_operand_feeder
// Assembles operand beats into 64-lane A/B vectors in two ping-pong banks.
// Each full vector is issued to the MAC array for exactly one cycle.
// oA/oB are zero on every other cycle, so the always-accumulating array is unaffected.
// Optional feature: define FEEDER_PERF_EN to add the 32-bit oIssueCnt counter and port.
module simd_operand_feeder
    import simd_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iValid,
    output logic        oReady,
    input  beat_vec_t   iA_beat,
    input  beat_vec_t   iB_beat,
    input  logic        iFlush,
    input  logic        iHold,
    output lane_vec_t   oA,
    output lane_vec_t   oB,
    output logic        oIssue,
    output logic        oBusy
`ifdef FEEDER_PERF_EN
    ,
    output logic [31:0] oIssueCnt
`endif
);

    // Handshake: a beat transfers on a rising edge when iValid && oReady.
    // oReady depends only on registered bank state, never on iValid.
    // iFlush in the same cycle drops the beat.

    logic        fill_bank;
    logic        drain_bank;
    beat_idx_t   beat_idx;

    bank_state_e bank_state [2];
    lane_vec_t   bank_a     [2];
    lane_vec_t   bank_b     [2];

    logic [1:0]  wr_sel;
    logic [1:0]  flush_sel;
    logic [1:0]  clr_sel;
    logic        accept;
    logic        issue;

    // Handshake and issue decisions from the current bank state.
    always_comb begin
        wr_sel    = '0;
        flush_sel = '0;
        clr_sel   = '0;
        oReady    = (bank_state[fill_bank] != FULL);
        accept    = iValid && oReady && !iFlush;
        issue     = (bank_state[drain_bank] == FULL) && !iHold;
        wr_sel[fill_bank]    = accept;
        flush_sel[fill_bank] = iFlush;
        clr_sel[drain_bank]  = issue;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        feeder_bank u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (wr_sel[g]),
            .wr_idx (beat_idx),
            .wr_a   (iA_beat),
            .wr_b   (iB_beat),
            .flush  (flush_sel[g]),
            .clr    (clr_sel[g]),
            .state  (bank_state[g]),
            .vec_a  (bank_a[g]),
            .vec_b  (bank_b[g])
        );
    end

    // Fill pointer and beat index.
    // A flush restarts the fill; the last beat hands over to the other bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_idx  <= '0;
            fill_bank <= 1'b0;
        end else if (iFlush) begin
            beat_idx  <= '0;
        end else if (accept) begin
            if (is_last_beat(beat_idx)) begin
                beat_idx  <= '0;
                fill_bank <= ~fill_bank;
            end else begin
                beat_idx  <= beat_idx + beat_idx_t'(1);
            end
        end
    end

    // Drain pointer plus registered outputs.
    // Zero is driven whenever nothing is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_bank <= 1'b0;
            oA         <= '0;
            oB         <= '0;
            oIssue     <= 1'b0;
        end else if (issue) begin
            drain_bank <= ~drain_bank;
            oA         <= bank_a[drain_bank];
            oB         <= bank_b[drain_bank];
            oIssue     <= 1'b1;
        end else begin
            oA         <= '0;
            oB         <= '0;
            oIssue     <= 1'b0;
        end
    end

`ifdef FEEDER_PERF_EN
    // Issued-vector counter; wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oIssueCnt <= '0;
        end else if (issue) begin
            oIssueCnt <= oIssueCnt + 32'd1;
        end
    end
`endif

    // Busy while any bank holds data (filling or full) or a vector is on the outputs.
    always_comb begin
        oBusy = (bank_state[0] != EMPTY) || (bank_state[1] != EMPTY) || oIssue;
    end

endmodule

// File: tb/tb_simd_operand_feeder.sv
// Directed self-checking bench for simd_operand_feeder.
// With FEEDER_PERF_EN defined, it also checks oIssueCnt.
module tb_simd_operand_feeder;
    import simd_feeder_pkg::*;

    localparam int VW        = LANES * BW;
    localparam int BEAT_BITS = BEAT_LANES * BW;
    typedef logic [VW-1:0] vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic      clk = 1'b0;
    logic      rst_n;
    logic      iValid;
    logic      iFlush;
    logic      iHold;
    beat_vec_t iA_beat;
    beat_vec_t iB_beat;
    logic      oReady;
    logic      oIssue;
    logic      oBusy;
    lane_vec_t oA;
    lane_vec_t oB;
`ifdef FEEDER_PERF_EN
    logic [31:0] oIssueCnt;
`endif

    always #5 clk = ~clk;

    simd_operand_feeder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iValid  (iValid),
        .oReady  (oReady),
        .iA_beat (iA_beat),
        .iB_beat (iB_beat),
        .iFlush  (iFlush),
        .iHold   (iHold),
        .oA      (oA),
        .oB      (oB),
        .oIssue  (oIssue),
        .oBusy   (oBusy)
`ifdef FEEDER_PERF_EN
        ,
        .oIssueCnt (oIssueCnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    int   n_assert    = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   stall_cnt   = 0;
    int   issue_total = 0;
    int   first_acc   = 0;
    int   last_acc    = 0;
    vec_t exp_a_q[$];
    vec_t exp_b_q[$];
    int   issue_cyc_q[$];

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every cycle: an issue must match the oldest expected vector; otherwise the outputs must be zero.
    task automatic check_outputs();
        vec_t ea;
        vec_t eb;
        if (oIssue === 1'b1) begin
            issue_cyc_q.push_back(cyc);
            issue_total++;
            if (exp_a_q.size() == 0) begin
                chk("unexpected_issue", vec_t'(oIssue), '0);
            end else begin
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                chk("issue_oA", oA, ea);
                chk("issue_oB", oB, eb);
            end
        end else begin
            chk("idle_oA_zero", oA, '0);
            chk("idle_oB_zero", oB, '0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    // Lane k = seed + step*k, truncated to BW.
    function automatic vec_t ramp(input int seed, input int step);
        vec_t v;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            v[k*BW +: BW] = BW'(seed + step * k);
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n   = 1'b0;
        iValid  = 1'b0;
        iFlush  = 1'b0;
        iHold   = 1'b0;
        iA_beat = '0;
        iB_beat = '0;
        exp_a_q.delete();
        exp_b_q.delete();
        issue_total = 0;
        tick();
        rst_n = 1'b1;
    endtask

    // Present beat b and hold it until oReady is seen (bounded).
    task automatic send_beat(input vec_t va, input vec_t vb, input int b);
        int budget;
        iA_beat = va[b*BEAT_BITS +: BEAT_BITS];
        iB_beat = vb[b*BEAT_BITS +: BEAT_BITS];
        iValid  = 1'b1;
        budget  = 0;
        while (oReady !== 1'b1 && budget < 50) begin
            stall_cnt++;
            tick();
            budget++;
        end
        if (oReady !== 1'b1) chk("beat_accept_timeout", vec_t'(oReady), vec_t'(1));
        last_acc = cyc;
        tick();
    endtask

    task automatic send_beats(input vec_t va, input vec_t vb, input int first, input int count);
        for (int b = first; b < first + count; b++) begin
            send_beat(va, vb, b);
            if (b == first) first_acc = last_acc;
        end
        iValid = 1'b0;
    endtask

    task automatic offer_vector(input vec_t va, input vec_t vb);
        exp_a_q.push_back(va);
        exp_b_q.push_back(vb);
        send_beats(va, vb, 0, BEATS);
    endtask

    // Run until every expected vector has issued (bounded), then a few spare cycles.
    task automatic drain();
        int budget;
        budget = 0;
        while (exp_a_q.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        chk("drain_pending", vec_t'(exp_a_q.size()), '0);
        tick();
        tick();
    endtask

    function automatic int q_at(input int i);
        return (issue_cyc_q.size() > i) ? issue_cyc_q[i] : -1000;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset state, then a single vector with A=k and B=1
        do_reset();
        chk("rst_oIssue", vec_t'(oIssue), '0);
        chk("rst_oReady", vec_t'(oReady), vec_t'(1));
        chk("rst_oBusy",  vec_t'(oBusy),  '0);
`ifdef FEEDER_PERF_EN
        chk("rst_cnt", vec_t'(oIssueCnt), '0);
`endif
        issue_cyc_q.delete();
        offer_vector(ramp(0, 1), ramp(1, 0));
        chk("s1_busy_full", vec_t'(oBusy), vec_t'(1));
        drain();
        chk("s1_issue_count", vec_t'(issue_cyc_q.size()), vec_t'(1));
        chk("s1_latency", vec_t'(q_at(0)), vec_t'(last_acc + 2));
        chk("s1_busy_idle", vec_t'(oBusy), '0);

        // 2: two vectors back to back, no bubbles, issues 8 cycles apart
        issue_cyc_q.delete();
        stall_cnt = 0;
        offer_vector(ramp(5, 2), ramp(200, 7));
        offer_vector(ramp(9, 3), ramp(0, 255));
        chk("s2_no_stall", vec_t'(stall_cnt), '0);
        drain();
        chk("s2_issue_count", vec_t'(issue_cyc_q.size()), vec_t'(2));
        chk("s2_spacing", vec_t'(q_at(1) - q_at(0)), vec_t'(BEATS));

        // 3: hold with both banks filled, stalled 17th beat, release
        issue_cyc_q.delete();
        stall_cnt = 0;
        iHold = 1'b1;
        offer_vector(ramp(17, 1), ramp(33, 2));
        offer_vector(ramp(100, 5), ramp(77, 9));
        chk("s3_fill_no_stall", vec_t'(stall_cnt), '0);
        exp_a_q.push_back(ramp(250, 11));
        exp_b_q.push_back(ramp(3, 13));
        iA_beat = '0;
        iB_beat = '0;
        iValid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s3_ready_low", vec_t'(oReady), '0);
            chk("s3_busy_held", vec_t'(oBusy), vec_t'(1));
            tick();
        end
        chk("s3_no_issue_while_held", vec_t'(issue_cyc_q.size()), '0);
        iHold = 1'b0;
        send_beats(ramp(250, 11), ramp(3, 13), 0, BEATS);
        drain();
        chk("s3_issue_count", vec_t'(issue_cyc_q.size()), vec_t'(3));
        chk("s3_17th_accept", vec_t'(first_acc), vec_t'(q_at(0)));
        chk("s3_banks_back_to_back", vec_t'(q_at(1) - q_at(0)), vec_t'(1));
        chk("s3_third_latency", vec_t'(q_at(2)), vec_t'(last_acc + 2));

        // 4: partial fill, flush together with a valid beat, then fresh vector
        issue_cyc_q.delete();
        send_beats(ramp(170, 3), ramp(85, 5), 0, 3);
        iA_beat = 64'h0123_4567_89ab_cdef;
        iB_beat = 64'hfeed_face_dead_beef;
        iValid  = 1'b1;
        iFlush  = 1'b1;
        tick();
        iFlush  = 1'b0;
        iValid  = 1'b0;
        chk("s4_busy_after_flush", vec_t'(oBusy), '0);
        chk("s4_ready_after_flush", vec_t'(oReady), vec_t'(1));
        offer_vector(ramp(60, 4), ramp(90, 6));
        drain();
        chk("s4_issue_count", vec_t'(issue_cyc_q.size()), vec_t'(1));
        chk("s4_latency", vec_t'(q_at(0)), vec_t'(last_acc + 2));

        // 5: reset with one FULL bank and 5 beats buffered drops everything
        issue_cyc_q.delete();
        iHold = 1'b1;
        send_beats(ramp(40, 1), ramp(41, 1), 0, BEATS);
        send_beats(ramp(42, 1), ramp(43, 1), 0, 5);
        chk("s5_busy_before_reset", vec_t'(oBusy), vec_t'(1));
        do_reset();
        chk("s5_busy_after_reset", vec_t'(oBusy), '0);
        chk("s5_ready_after_reset", vec_t'(oReady), vec_t'(1));
        for (int i = 0; i < 4; i++) tick();
        chk("s5_no_stale_issue", vec_t'(issue_cyc_q.size()), '0);
        offer_vector(ramp(11, 13), ramp(7, 3));
        drain();
        chk("s5_issue_count", vec_t'(issue_cyc_q.size()), vec_t'(1));

        // 6: ten streamed vectors after a fresh reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            offer_vector(ramp(i * 7, i + 1), ramp(255 - i, 2));
        end
        drain();
        chk("s6_issues_seen", vec_t'(issue_total), vec_t'(10));
`ifdef FEEDER_PERF_EN
        chk("s6_issue_cnt", vec_t'(oIssueCnt), vec_t'(10));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
